// File: rtl/spi_xfer_queue_if.sv
// Host-side command/RX bundle for spi_xfer_queue.
// Error flags exist only when SPI_XFER_QUEUE_ERR_EN is defined.
interface spi_xfer_queue_if #(
    parameter int CMD_DEPTH = 8
);
    localparam int CCW = $clog2(CMD_DEPTH + 1);

    logic           i_cmd_valid;
    logic [2:0]     i_cmd_slave;
    logic [7:0]     i_cmd_data;
    logic           o_cmd_ready;
    logic [CCW-1:0] o_cmd_count;
    logic           i_rx_pop;
    logic           o_rx_valid;
    logic [7:0]     o_rx_data;
    logic [2:0]     o_rx_slave;
    logic           o_busy;
`ifdef SPI_XFER_QUEUE_ERR_EN
    logic           o_err_cmd_ovf;
    logic           o_err_rx_unf;
    logic           i_err_clr;
`endif

    modport master (
`ifdef SPI_XFER_QUEUE_ERR_EN
        input  o_err_cmd_ovf, o_err_rx_unf,
        output i_err_clr,
`endif
        output i_cmd_valid, i_cmd_slave, i_cmd_data, i_rx_pop,
        input  o_cmd_ready, o_cmd_count, o_rx_valid,
        input  o_rx_data, o_rx_slave, o_busy
    );

    modport slave (
`ifdef SPI_XFER_QUEUE_ERR_EN
        output o_err_cmd_ovf, o_err_rx_unf,
        input  i_err_clr,
`endif
        input  i_cmd_valid, i_cmd_slave, i_cmd_data, i_rx_pop,
        output o_cmd_ready, o_cmd_count, o_rx_valid,
        output o_rx_data, o_rx_slave, o_busy
    );
endinterface

// File: rtl/spi_xfer_queue.sv
// spi_xfer_queue: buffered {slave,byte} command front-end for spi_master.
// Define SPI_XFER_QUEUE_ERR_EN to add sticky overflow/underflow flags.
module spi_xfer_queue #(
    parameter int CMD_DEPTH = 8,
    parameter int RX_DEPTH  = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    spi_xfer_queue_if.slave host,
    output logic            o_m_tx_data_valid,
    output logic [2:0]      o_m_slave_select,
    output logic [7:0]      o_m_tx_data_byte,
    input  logic            i_m_tx_ready,
    input  logic            i_m_rx_data_valid,
    input  logic [7:0]      i_m_rx_data_byte
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int CCW = $clog2(CMD_DEPTH + 1);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int RCW = $clog2(RX_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t         state_q;
    logic           tx_valid_q;
    logic [2:0]     sel_q;
    logic [7:0]     byte_q;

    logic [10:0]    cmd_mem_q [CMD_DEPTH];
    logic [CAW-1:0] cmd_wp_q;
    logic [CAW-1:0] cmd_rp_q;
    logic [CCW-1:0] cmd_cnt_q;
    logic [CCW-1:0] cmd_cnt_d;
    logic           cmd_rdy_q;

    logic [10:0]    rx_mem_q [RX_DEPTH];
    logic [RAW-1:0] rx_wp_q;
    logic [RAW-1:0] rx_rp_q;
    logic [RCW-1:0] rx_cnt_q;
    logic [RCW-1:0] rx_cnt_d;

    logic cmd_push;
    logic cmd_pop;
    logic rx_push;
    logic rx_pop;
    logic rx_free;
    logic cap;

    // Only IDLE starts a transfer and only a capture fills RX, so the
    // free slot seen at issue stays reserved until its byte returns.
    assign rx_free  = rx_cnt_q != RCW'(RX_DEPTH);
    assign cmd_push = host.i_cmd_valid & cmd_rdy_q;
    assign cmd_pop  = (state_q == IDLE) & (cmd_cnt_q != '0)
                    & i_m_tx_ready & rx_free;
    assign cap      = i_m_rx_data_valid
                    & ((state_q == WAIT_START) | (state_q == WAIT_DONE));
    assign rx_push  = cap;
    assign rx_pop   = host.i_rx_pop & (rx_cnt_q != '0);

    always_comb begin
        cmd_cnt_d = cmd_cnt_q;
        unique case ({cmd_push, cmd_pop})
            2'b10:   cmd_cnt_d = cmd_cnt_q + CCW'(1);
            2'b01:   cmd_cnt_d = cmd_cnt_q - CCW'(1);
            default: cmd_cnt_d = cmd_cnt_q;
        endcase
    end

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        unique case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + RCW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - RCW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_wp_q  <= '0;
            cmd_rp_q  <= '0;
            cmd_cnt_q <= '0;
            cmd_rdy_q <= 1'b1;
            for (int i = 0; i < CMD_DEPTH; i++) cmd_mem_q[i] <= '0;
        end else begin
            if (cmd_push) begin
                cmd_mem_q[cmd_wp_q] <= {host.i_cmd_slave, host.i_cmd_data};
                cmd_wp_q            <= cmd_wp_q + CAW'(1);
            end
            if (cmd_pop) cmd_rp_q <= cmd_rp_q + CAW'(1);
            cmd_cnt_q <= cmd_cnt_d;
            cmd_rdy_q <= cmd_cnt_d != CCW'(CMD_DEPTH);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= '0;
        end else begin
            if (rx_push) begin
                rx_mem_q[rx_wp_q] <= {sel_q, i_m_rx_data_byte};
                rx_wp_q           <= rx_wp_q + RAW'(1);
            end
            if (rx_pop) rx_rp_q <= rx_rp_q + RAW'(1);
            rx_cnt_q <= rx_cnt_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            sel_q      <= '0;
            byte_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_pop) begin
                        state_q           <= ISSUE;
                        tx_valid_q        <= 1'b1;
                        {sel_q, byte_q}   <= cmd_mem_q[cmd_rp_q];
                    end
                end
                ISSUE: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= WAIT_START;
                end
                WAIT_START: begin
                    if (cap) state_q <= IDLE;
                    else if (!i_m_tx_ready) state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (cap) state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SPI_XFER_QUEUE_ERR_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (host.i_cmd_valid & ~cmd_rdy_q)
                   | (ovf_q & ~host.i_err_clr);
            unf_q <= (host.i_rx_pop & (rx_cnt_q == '0))
                   | (unf_q & ~host.i_err_clr);
        end
    end

    assign host.o_err_cmd_ovf = ovf_q;
    assign host.o_err_rx_unf  = unf_q;
`endif

    assign host.o_cmd_ready = cmd_rdy_q;
    assign host.o_cmd_count = cmd_cnt_q;
    assign host.o_rx_valid  = rx_cnt_q != '0;
    assign {host.o_rx_slave, host.o_rx_data} = rx_mem_q[rx_rp_q];
    assign host.o_busy      = (state_q != IDLE) | (cmd_cnt_q != '0);

    assign o_m_tx_data_valid = tx_valid_q;
    assign o_m_slave_select  = sel_q;
    assign o_m_tx_data_byte  = byte_q;
endmodule

// File: tb/tb_spi_xfer_queue.sv
// Scoreboard bench for spi_xfer_queue with a loopback spi_master model.
// Error-flag checks are compiled in when SPI_XFER_QUEUE_ERR_EN is defined.
module tb_spi_xfer_queue;
    localparam int CMD_DEPTH = 8;
    localparam int RX_DEPTH  = 8;
    localparam int CPB       = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_xfer_queue_if #(.CMD_DEPTH(CMD_DEPTH)) bus ();

    logic       m_txv;
    logic [2:0] m_sel;
    logic [7:0] m_byte;
    logic       m_rdy;
    logic       m_rxv;
    logic [7:0] m_rxb;

    spi_xfer_queue #(
        .CMD_DEPTH(CMD_DEPTH),
        .RX_DEPTH (RX_DEPTH)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .host             (bus),
        .o_m_tx_data_valid(m_txv),
        .o_m_slave_select (m_sel),
        .o_m_tx_data_byte (m_byte),
        .i_m_tx_ready     (m_rdy),
        .i_m_rx_data_valid(m_rxv),
        .i_m_rx_data_byte (m_rxb)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_issue  = 0;
    logic [10:0] exp_cmd[$];
    logic [10:0] exp_rx[$];
    bit          pop_en    = 0;
    bit          force_pop = 0;
    logic        prev_txv  = 1'b0;
    logic [10:0] iss_e;
    logic [10:0] rx_e;
    logic [7:0]  m_hold;
    int          iss0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic bad(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got event expected none at %0t", nm, $time);
    endtask

    function automatic logic [31:0] outs_vec();
        return {2'b0, m_txv, m_sel, m_byte, bus.o_rx_valid, bus.o_rx_data,
                bus.o_rx_slave, bus.o_busy, bus.o_cmd_count, bus.o_cmd_ready};
    endfunction

    // Called at posedge+1; holds the push for exactly one edge.
    task automatic push(input logic [2:0] s, input logic [7:0] d,
                        input bit acc);
        chk("cmd_ready_at_push", 32'(bus.o_cmd_ready), 32'(acc));
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_slave = s;
        bus.i_cmd_data  = d;
        if (acc) begin
            exp_cmd.push_back({s, d});
            exp_rx.push_back({s, d});
        end
        @(posedge clk);
        #1 bus.i_cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_rx.size() != 0 || bus.o_busy || bus.o_rx_valid)
               && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_in_budget", 32'(k < budget), 1);
    endtask

    // spi_master stand-in: MOSI looped to MISO, 8 bits of CPB clocks.
    initial begin
        m_rdy = 1'b1;
        m_rxv = 1'b0;
        m_rxb = '0;
        forever begin
            @(negedge clk);
            if (m_txv && m_rdy) begin
                m_hold = m_byte;
                @(posedge clk);
                #1 m_rdy = 1'b0;
                repeat (8 * CPB) @(posedge clk);
                #1 m_rxv = 1'b1;
                m_rxb = m_hold;
                @(posedge clk);
                #1 m_rxv = 1'b0;
                repeat (CPB) @(posedge clk);
                #1 m_rdy = 1'b1;
            end
        end
    end

    initial begin
        bus.i_rx_pop = 1'b0;
        forever begin
            @(posedge clk);
            #2 bus.i_rx_pop = (pop_en && bus.o_rx_valid) || force_pop;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_txv) begin
            n_issue++;
            chk("issue_single_cycle", 32'(prev_txv), 0);
            if (exp_cmd.size() == 0) bad("issue_unexpected");
            else begin
                iss_e = exp_cmd.pop_front();
                chk("issue_cmd", 32'({m_sel, m_byte}), 32'(iss_e));
            end
        end
        prev_txv = m_txv;
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.i_rx_pop && bus.o_rx_valid) begin
            if (exp_rx.size() == 0) bad("rx_unexpected");
            else begin
                rx_e = exp_rx.pop_front();
                chk("rx_head", 32'({bus.o_rx_slave, bus.o_rx_data}),
                    32'(rx_e));
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got no end expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_slave = '0;
        bus.i_cmd_data  = '0;
`ifdef SPI_XFER_QUEUE_ERR_EN
        bus.i_err_clr = 1'b0;
`endif
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_outputs", outs_vec(), 32'h1);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // 1. idle after reset
        repeat (20) @(posedge clk);
        #1;
        chk("idle_cmd_ready", 32'(bus.o_cmd_ready), 1);
        chk("idle_rx_valid", 32'(bus.o_rx_valid), 0);
        chk("idle_busy", 32'(bus.o_busy), 0);
        chk("idle_no_pulse", 32'(n_issue), 0);

`ifdef SPI_XFER_QUEUE_ERR_EN
        chk("err_ovf_reset", 32'(bus.o_err_cmd_ovf), 0);
        chk("err_unf_reset", 32'(bus.o_err_rx_unf), 0);
        force_pop = 1;
        @(posedge clk);
        #1 force_pop = 0;
        @(posedge clk);
        #1;
        chk("err_unf_set", 32'(bus.o_err_rx_unf), 1);
        force_pop = 1;
        bus.i_err_clr = 1'b1;
        @(posedge clk);
        #1 force_pop = 0;
        bus.i_err_clr = 1'b0;
        @(posedge clk);
        #1;
        chk("err_unf_set_wins", 32'(bus.o_err_rx_unf), 1);
        bus.i_err_clr = 1'b1;
        @(posedge clk);
        #1 bus.i_err_clr = 1'b0;
        chk("err_unf_clr", 32'(bus.o_err_rx_unf), 0);
`endif

        // 2. single transfer and issue latency
        pop_en = 1;
        push(3'd0, 8'hA5, 1);
        @(negedge clk);
        chk("lat_cycle1", 32'(m_txv), 0);
        @(negedge clk);
        chk("lat_cycle2_pulse", 32'(m_txv), 1);
        @(negedge clk);
        chk("lat_cycle3", 32'(m_txv), 0);
        @(posedge clk);
        #1;
        wait_drain(200);

        // 3. burst of four, order and tags preserved
        push(3'd1, 8'hDE, 1);
        push(3'd1, 8'hAD, 1);
        push(3'd2, 8'hBE, 1);
        push(3'd3, 8'hEF, 1);
        wait_drain(1000);

        // 4. fill RX, then overfill the command FIFO
        pop_en = 0;
        iss0 = n_issue;
        for (int i = 0; i < RX_DEPTH; i++) push(3'(i), 8'h10 + 8'(i), 1);
        begin
            int k = 0;
            while (bus.o_busy && k < 1000) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk("fill_in_budget", 32'(k < 1000), 1);
        end
        chk("fill_issues", 32'(n_issue - iss0), 32'(RX_DEPTH));
        chk("fill_rx_valid", 32'(bus.o_rx_valid), 1);
        for (int i = 0; i <= CMD_DEPTH; i++)
            push(3'(7 - i), 8'h80 + 8'(i), i < CMD_DEPTH);
        chk("full_cmd_ready", 32'(bus.o_cmd_ready), 0);
        chk("full_cmd_count", 32'(bus.o_cmd_count), 32'(CMD_DEPTH));
        chk("full_busy", 32'(bus.o_busy), 1);
`ifdef SPI_XFER_QUEUE_ERR_EN
        chk("err_ovf_set", 32'(bus.o_err_cmd_ovf), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("err_ovf_sticky", 32'(bus.o_err_cmd_ovf), 1);
        bus.i_err_clr = 1'b1;
        @(posedge clk);
        #1 bus.i_err_clr = 1'b0;
        chk("err_ovf_clr", 32'(bus.o_err_cmd_ovf), 0);
`endif
        repeat (100) @(posedge clk);
        #1;
        chk("stall_no_issue", 32'(n_issue - iss0), 32'(RX_DEPTH));
        pop_en = 1;
        wait_drain(3000);
        chk("drain_issues", 32'(n_issue - iss0),
            32'(RX_DEPTH + CMD_DEPTH));

        // 5. reset in WAIT_DONE drops the in-flight byte
        push(3'd4, 8'h5A, 1);
        begin
            int k = 0;
            while (!m_txv && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("rst_issue_seen", 32'(m_txv), 1);
        end
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midxfer_reset_outputs", outs_vec(), 32'h1);
        exp_rx.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("post_rst_rx_valid", 32'(bus.o_rx_valid), 0);
        chk("post_rst_busy", 32'(bus.o_busy), 0);
        push(3'd5, 8'h3C, 1);
        wait_drain(300);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
